// File: rtl/alu_sel_pkg.sv
// Shared constants and helpers for the ALU result select/arbitration block.
package alu_sel_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Index width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mux_sel_arb_reg_rr_arbiter.sv
// Combinational round-robin arbiter: rotate by ptr, priority-encode, un-rotate.
module rr_arbiter
  import alu_sel_pkg::*;
#(
  parameter  int unsigned N  = 8,
  localparam int unsigned SW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] gnt_idx,
  output logic          gnt_any
);

  // One extra bit so ptr+offset up to 2N-2 never overflows.
  localparam int unsigned XW = SW + 1;

  logic [2*N-1:0] req2;
  logic [N-1:0]   rot;
  logic [XW-1:0]  base;
  logic [XW-1:0]  off;
  logic [XW-1:0]  sum;

  assign req2 = {req, req};

  // An out-of-range pointer is treated as 0 so the rotation stays in bounds.
  assign base = ({1'b0, ptr} < XW'(N)) ? {1'b0, ptr} : '0;

  // Rotate so that channel ptr lands at position 0.
  always_comb begin
    rot = '0;
    for (int unsigned k = 0; k < N; k++) begin
      rot[k] = req2[base + XW'(k)];
    end
  end

  // Lowest set position in the rotated vector wins.
  always_comb begin
    gnt_any = 1'b0;
    off     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        gnt_any = 1'b1;
        off     = XW'(k);
      end
    end
  end

  // Un-rotate back to an absolute channel index (mod N, any N).
  assign sum     = base + off;
  assign gnt_idx = (sum >= XW'(N)) ? SW'(sum - XW'(N)) : SW'(sum);

endmodule

// File: rtl/mux_sel_arb_reg.sv
// Registered N:1 result mux with direct or round-robin source selection.
module mux_sel_arb_reg
  import alu_sel_pkg::*;
#(
  parameter  int unsigned N  = 8,
  parameter  int unsigned W  = 6,
  localparam int unsigned SW = clog2_min1(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  input  logic [N*W-1:0]  d,
  input  logic [N-1:0]    d_valid,
  output logic [N-1:0]    d_ready,
  output logic [W-1:0]    y,
  output logic            y_valid,
  input  logic            y_ready,
  output logic [SW-1:0]   y_src
);

  localparam int unsigned XW = SW + 1;

  logic [SW-1:0] ptr;
  logic          load_en_c;
  logic          sel_ok_c;
  logic          dir_any_c;
  logic [SW-1:0] rr_idx_c;
  logic          rr_any_c;
  logic [SW-1:0] grant_idx_c;
  logic          grant_any_c;
  logic          xfer_c;
  logic [W-1:0]  din_c;
  logic [SW-1:0] ptr_next_c;

  rr_arbiter #(.N(N)) u_rr_arbiter (
    .req     (d_valid),
    .ptr     (ptr),
    .gnt_idx (rr_idx_c),
    .gnt_any (rr_any_c)
  );

  // Output register can accept when empty or draining this cycle.
  assign load_en_c = !y_valid || y_ready;

  // Direct mode grants only an in-range, valid channel.
  assign sel_ok_c  = ({1'b0, sel} < XW'(N));
  assign dir_any_c = sel_ok_c ? d_valid[sel] : 1'b0;

  // Grant source mux between direct and round-robin selection.
  always_comb begin
    grant_idx_c = sel;
    grant_any_c = dir_any_c;
    if (mode == MODE_RR) begin
      grant_idx_c = rr_idx_c;
      grant_any_c = rr_any_c;
    end
  end

  assign xfer_c = !rst && load_en_c && grant_any_c;

  // One-hot accept strobe toward the granted source.
  always_comb begin
    d_ready = '0;
    if (xfer_c) begin
      d_ready[grant_idx_c] = 1'b1;
    end
  end

  // Data mux for the granted channel.
  always_comb begin
    din_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_idx_c == SW'(i)) begin
        din_c = d[i*W +: W];
      end
    end
  end

  // Pointer advances past the granted channel, wrapping at N-1.
  assign ptr_next_c = (grant_idx_c == SW'(N - 1)) ? '0 : SW'(grant_idx_c + SW'(1));

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      y       <= '0;
      y_valid <= 1'b0;
      y_src   <= '0;
      ptr     <= '0;
    end else if (load_en_c) begin
      if (grant_any_c) begin
        y       <= din_c;
        y_src   <= grant_idx_c;
        y_valid <= 1'b1;
        if (mode == MODE_RR) begin
          ptr <= ptr_next_c;
        end
      end else begin
        y_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_sel_arb_reg.sv
// Directed self-checking bench for mux_sel_arb_reg (N=8/W=6 and N=5/W=4).
module tb_mux_sel_arb_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: N=8, W=6
  logic        a_rst, a_mode, a_y_ready, a_y_valid;
  logic [2:0]  a_sel, a_y_src;
  logic [47:0] a_d;
  logic [7:0]  a_d_valid, a_d_ready;
  logic [5:0]  a_y;

  // Instance B: N=5, W=4
  logic        b_rst, b_mode, b_y_ready, b_y_valid;
  logic [2:0]  b_sel, b_y_src;
  logic [19:0] b_d;
  logic [4:0]  b_d_valid, b_d_ready;
  logic [3:0]  b_y;

  mux_sel_arb_reg #(.N(8), .W(6)) u_dut_a (
    .clk(clk), .rst(a_rst), .mode(a_mode), .sel(a_sel), .d(a_d),
    .d_valid(a_d_valid), .d_ready(a_d_ready), .y(a_y), .y_valid(a_y_valid),
    .y_ready(a_y_ready), .y_src(a_y_src)
  );

  mux_sel_arb_reg #(.N(5), .W(4)) u_dut_b (
    .clk(clk), .rst(b_rst), .mode(b_mode), .sel(b_sel), .d(b_d),
    .d_valid(b_d_valid), .d_ready(b_d_ready), .y(b_y), .y_valid(b_y_valid),
    .y_ready(b_y_ready), .y_src(b_y_src)
  );

  logic [5:0] dva [8] = '{6'h01, 6'h0B, 6'h15, 6'h1F, 6'h09, 6'h2A, 6'h33, 6'h3C};
  logic [3:0] dvb [5] = '{4'h3, 4'h6, 4'h9, 4'hC, 4'hF};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  int ga [6] = '{0, 2, 5, 7, 0, 2};
  int gb [4] = '{4, 0, 4, 0};

  initial begin
    for (int i = 0; i < 8; i++) a_d[i*6 +: 6] = dva[i];
    for (int i = 0; i < 5; i++) b_d[i*4 +: 4] = dvb[i];
    a_rst = 1'b1; a_mode = 1'b1; a_sel = 3'd0; a_d_valid = 8'hFF; a_y_ready = 1'b1;
    b_rst = 1'b1; b_mode = 1'b1; b_sel = 3'd0; b_d_valid = 5'h00; b_y_ready = 1'b1;
    #2;

    // Reset with all sources valid: no accept strobe, outputs cleared.
    for (int c = 0; c < 2; c++) begin
      settle();
      check("rst_d_ready", 32'(a_d_ready), 32'(0));
      step();
      check("rst_y", 32'(a_y), 32'(0));
      check("rst_y_valid", 32'(a_y_valid), 32'(0));
      check("rst_y_src", 32'(a_y_src), 32'(0));
    end

    // Round-robin fairness from ptr=0 over d_valid=1010_0101.
    a_rst = 1'b0; a_d_valid = 8'b1010_0101;
    for (int c = 0; c < 6; c++) begin
      settle();
      check("rr_d_ready", 32'(a_d_ready), 32'(1) << ga[c]);
      step();
      check("rr_y_src", 32'(a_y_src), 32'(ga[c]));
      check("rr_y", 32'(a_y), 32'(dva[ga[c]]));
      check("rr_y_valid", 32'(a_y_valid), 32'(1));
    end

    // Backpressure: word from channel 2 held three cycles, then ptr=3 grants 5.
    a_y_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      check("bp_d_ready", 32'(a_d_ready), 32'(0));
      step();
      check("bp_y", 32'(a_y), 32'(dva[2]));
      check("bp_y_src", 32'(a_y_src), 32'(2));
      check("bp_y_valid", 32'(a_y_valid), 32'(1));
    end
    a_y_ready = 1'b1;
    settle();
    check("bp_release_d_ready", 32'(a_d_ready), 32'(8'h20));
    step();
    check("bp_release_y_src", 32'(a_y_src), 32'(5));

    // Direct select of channel 5, then channel 5 drops valid.
    a_mode = 1'b0; a_sel = 3'd5; a_d_valid = 8'hFF;
    settle();
    check("dir_d_ready", 32'(a_d_ready), 32'(8'h20));
    step();
    check("dir_y", 32'(a_y), 32'(6'h2A));
    check("dir_y_src", 32'(a_y_src), 32'(5));
    check("dir_y_valid", 32'(a_y_valid), 32'(1));
    a_d_valid = 8'hDF;
    settle();
    check("dir_novalid_d_ready", 32'(a_d_ready), 32'(0));
    step();
    check("dir_novalid_y_valid", 32'(a_y_valid), 32'(0));
    check("dir_novalid_y_hold", 32'(a_y), 32'(6'h2A));

    // Back to round-robin: ptr=6 survived the direct-mode excursion.
    a_mode = 1'b1; a_d_valid = 8'hFF;
    settle();
    check("mode_back_d_ready", 32'(a_d_ready), 32'(8'h40));
    step();
    check("mode_back_y_src", 32'(a_y_src), 32'(6));

    // Reset while holding 6'h15 under backpressure.
    a_mode = 1'b0; a_sel = 3'd2; a_d_valid = 8'h04;
    step();
    check("pre_rst_y", 32'(a_y), 32'(6'h15));
    a_y_ready = 1'b0; a_d_valid = 8'h00;
    step();
    check("pre_rst_hold_valid", 32'(a_y_valid), 32'(1));
    a_rst = 1'b1; a_d_valid = 8'hFF;
    settle();
    check("mid_rst_d_ready", 32'(a_d_ready), 32'(0));
    step();
    check("mid_rst_y", 32'(a_y), 32'(0));
    check("mid_rst_y_valid", 32'(a_y_valid), 32'(0));
    a_rst = 1'b0; a_y_ready = 1'b1; a_mode = 1'b1; a_d_valid = 8'h00;
    step();
    check("post_rst_no_replay", 32'(a_y_valid), 32'(0));
    a_d_valid = 8'hFF;
    settle();
    check("post_rst_ptr0", 32'(a_d_ready), 32'(8'h01));

    // N=5: move ptr to 1, then alternate 4,0,4,0 across the non-power-of-2 wrap.
    b_rst = 1'b0; b_d_valid = 5'b00001;
    settle();
    check("b_first_d_ready", 32'(b_d_ready), 32'(5'b00001));
    step();
    check("b_first_y_src", 32'(b_y_src), 32'(0));
    b_d_valid = 5'b10001;
    for (int c = 0; c < 4; c++) begin
      settle();
      check("b_wrap_d_ready", 32'(b_d_ready), 32'(1) << gb[c]);
      step();
      check("b_wrap_y_src", 32'(b_y_src), 32'(gb[c]));
      check("b_wrap_y", 32'(b_y), 32'(dvb[gb[c]]));
    end

    // N=5 direct mode with sel=6 never grants.
    b_mode = 1'b0; b_sel = 3'd6; b_d_valid = 5'b11111;
    settle();
    check("b_sel6_d_ready", 32'(b_d_ready), 32'(0));
    step();
    check("b_sel6_y_valid", 32'(b_y_valid), 32'(0));
    step();
    check("b_sel6_y_valid_stays", 32'(b_y_valid), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mux_sel_arb_reg.md
Name: mux_sel_arb_reg

Overview:
- Parametrised, registered successor to the fixed 8:1 6-bit ALU result multiplexer.
- Selects one of N W-bit sources onto a single pipelined output.
- Two selection modes:
  - direct: the SEL input picks the source.
  - round-robin: a fair rotating arbiter picks among valid sources.
- Valid/ready handshake on every input and on the output; sits between the ALU function units and the result/writeback stage.

Parameters:
- N, 8, number of input channels (N >= 2).
- W, 6, data width per channel.
- SW, $clog2(N), select/source-index width (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = direct select, 1 = round-robin.
- sel  input  SW  channel index used in direct mode.
- d  input  N*W  flattened inputs; channel i = d[i*W +: W].
- d_valid  input  N  per-channel data valid.
- d_ready  output  N  per-channel accept strobe; at most one bit high.
- y  output  W  registered selected data.
- y_valid  output  1  y holds an unconsumed word.
- y_ready  input  1  downstream accepts y this cycle.
- y_src  output  SW  index of the channel that produced y.

Behaviour:
- Reset (rst=1 at a clock edge): y=0, y_valid=0, y_src=0, round-robin pointer ptr=0.
- d_ready is forced to 0 in any cycle where rst=1. Reset mid-transfer discards the held word; no partial state survives.
- load_en = !y_valid || y_ready. The output register may refill in the same cycle it drains, giving full throughput of 1 word/cycle.
- Grant (combinational):
  - Direct mode: grant = sel when sel < N and d_valid[sel]=1; otherwise no grant. sel >= N never grants and never raises d_ready.
  - Round-robin mode: scan channels ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (mod N). The first with d_valid=1 is granted; none valid gives no grant.
- Handshakes:
  - d_ready[i] = load_en && grant_exists && grant==i; all other bits are 0.
  - Input transfer occurs on channel i when d_valid[i] && d_ready[i].
  - On that edge: y <= d[i], y_src <= i, y_valid <= 1.
  - On a load_en edge with no grant: y_valid <= 0 if y_ready=1. y and y_src hold their previous values; they are don't-care while y_valid=0, but the RTL keeps them stable.
  - Backpressure (y_valid=1, y_ready=0): y, y_src and y_valid hold; all d_ready=0.
- Latency: input accept to y_valid is exactly 1 cycle.
- Pointer update: in round-robin mode, on each input transfer ptr <= (grant+1) mod N. This includes the wrap from N-1 to 0, and must be correct for non-power-of-2 N.
- In direct mode ptr holds.
- A mode change takes effect on the next grant evaluation. ptr is never reset by a mode change.
- Protocol rules:
  - d_valid must not depend combinationally on d_ready.
  - A source with d_valid=1 keeps d[i] stable until it is accepted.
  - The block tolerates d_valid dropping without a transfer; no error is raised.
- The path from y_ready to d_ready is combinational by design, for single-cycle throughput.

Decomposition:
- Shared package alu_sel_pkg:
  - Constants MODE_DIRECT=1'b0 and MODE_RR=1'b1.
  - A function clog2_min1(N) returning max(1, $clog2(N)) for the SW derivation.
- One sub-module: rr_arbiter.
  - Purely combinational; parameter N.
  - Inputs: req[N], ptr[SW]. Outputs: gnt_idx[SW], gnt_any.
  - Implemented as a rotate / priority-encode / un-rotate.
- The top level holds the output register, the pointer register and the direct/RR grant mux.

Test Plan:
- Reset/idle: assert rst for 2 cycles with all d_valid=1 -> y=0, y_valid=0, y_src=0, d_ready=0 throughout; after release, ptr=0 is observed on the first RR grant (channel 0).
- Direct select, N=8, W=6, mode=0, y_ready=1: sel=5, d_valid=8'hFF, d[5]=6'h2A -> d_ready=8'h20 that cycle; next cycle y=6'h2A, y_src=5, y_valid=1. Then set sel=5, d_valid[5]=0 -> d_ready=0 and y_valid falls the following cycle.
- Round-robin fairness, mode=1, y_ready=1, d_valid=8'b1010_0101 held -> grants in order 0,2,5,7,0,2,... on consecutive cycles, y_src matching, one transfer per cycle.
- Backpressure, mode=1: hold y_ready=0 for 3 cycles while y_valid=1 -> y and y_src frozen, d_ready=0, ptr unchanged. Raise y_ready -> the same cycle accepts the next granted channel, no bubble.
- Non-power-of-2 wrap, N=5, W=4, mode=1, d_valid=5'b10001 -> grants alternate 4,0,4,0, with ptr going 4 -> 0 -> 1 -> 0 correctly. In direct mode, sel=6 gives no d_ready and y_valid stays 0.
- Reset mid-operation: y_valid=1, y_ready=0, y=6'h15; assert rst for 1 cycle -> next cycle y=0, y_valid=0, ptr=0; the word 6'h15 is never presented again.
